// File: rtl/vmicro16_intc_apb.sv
// APB interrupt controller: edge-detects sources, latches per-source data, and
// presents the lowest-index unmasked pending source to the core via irq/ack/EOI.
module vmicro16_intc_apb #(
    parameter int unsigned BUS_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_INT    = 8,
    parameter int unsigned VEC_BITS   = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [BUS_WIDTH-1:0]           S_PADDR,
    input  logic                           S_PWRITE,
    input  logic                           S_PSELx,
    input  logic                           S_PENABLE,
    input  logic [DATA_WIDTH-1:0]          S_PWDATA,
    output logic [DATA_WIDTH-1:0]          S_PRDATA,
    output logic                           S_PREADY,
    input  logic [NUM_INT-1:0]             ints,
    input  logic [NUM_INT*DATA_WIDTH-1:0]  ints_data,
    output logic                           irq,
    output logic [VEC_BITS-1:0]            irq_vec,
    output logic [DATA_WIDTH-1:0]          irq_data,
    input  logic                           irq_ack
);

    localparam logic [1:0] A_PEND   = 2'd0;
    localparam logic [1:0] A_MASK   = 2'd1;
    localparam logic [1:0] A_STAT   = 2'd2;
    localparam logic [1:0] A_SWTRIG = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERV} state_t;

    state_t                  state_q, state_d;
    logic                    irq_q, irq_d;
    logic [VEC_BITS-1:0]     irq_vec_q, irq_vec_d;
    logic [DATA_WIDTH-1:0]   irq_data_q, irq_data_d;
    logic [NUM_INT-1:0]      ints_prev_q, pend_q, pend_d, mask_q, mask_d;
    logic [DATA_WIDTH-1:0]   data_lat_q [NUM_INT];

    logic                    en_c, we_c;
    logic [1:0]              addr_c;
    logic [NUM_INT-1:0]      wbits_c, rise_c, set_c, clr_c, avail_c;
    logic [VEC_BITS-1:0]     win_vec_c;
    logic [DATA_WIDTH-1:0]   win_data_c, stat_c, rdata_c;
    logic                    unused_c;

    assign en_c     = S_PSELx & S_PENABLE;
    assign we_c     = en_c & S_PWRITE;
    assign addr_c   = S_PADDR[1:0];
    assign wbits_c  = S_PWDATA[NUM_INT-1:0];
    assign rise_c   = ints & ~ints_prev_q;
    assign avail_c  = pend_q & mask_q;
    assign unused_c = ^{S_PADDR[BUS_WIDTH-1:2], S_PWDATA[DATA_WIDTH-1:NUM_INT]};

    // Pending set/clear and mask write; a set in the same cycle beats any clear
    always_comb begin
        set_c  = rise_c;
        clr_c  = '0;
        mask_d = mask_q;
        if (we_c) begin
            case (addr_c)
                A_PEND:   clr_c  = wbits_c;
                A_MASK:   mask_d = wbits_c;
                A_SWTRIG: set_c  = rise_c | wbits_c;
                default:  ;
            endcase
        end
        if (state_q == ST_REQ && irq_ack) begin
            clr_c = clr_c | (NUM_INT'(1) << irq_vec_q);
        end
        pend_d = (pend_q & ~clr_c) | set_c;
    end

    // Lowest set index of avail wins; scan downward so the last hit is the lowest
    always_comb begin
        win_vec_c  = '0;
        win_data_c = '0;
        for (int i = int'(NUM_INT) - 1; i >= 0; i--) begin
            if (avail_c[i]) begin
                win_vec_c  = VEC_BITS'(i);
                win_data_c = data_lat_q[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        irq_d      = irq_q;
        irq_vec_d  = irq_vec_q;
        irq_data_d = irq_data_q;
        case (state_q)
            ST_IDLE: begin
                if (|avail_c) begin
                    state_d    = ST_REQ;
                    irq_d      = 1'b1;
                    irq_vec_d  = win_vec_c;
                    irq_data_d = win_data_c;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_d = ST_SERV;
                    irq_d   = 1'b0;
                end
            end
            ST_SERV: begin
                if (we_c && addr_c == A_STAT) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stat_c                 = '0;
        stat_c[DATA_WIDTH-1]   = (state_q == ST_SERV);
        stat_c[DATA_WIDTH-2]   = (state_q == ST_REQ);
        stat_c[VEC_BITS-1:0]   = irq_vec_q;
        rdata_c                = '0;
        if (en_c && !S_PWRITE) begin
            case (addr_c)
                A_PEND:  rdata_c = DATA_WIDTH'(pend_q);
                A_MASK:  rdata_c = DATA_WIDTH'(mask_q);
                A_STAT:  rdata_c = stat_c;
                default: rdata_c = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            irq_q       <= 1'b0;
            irq_vec_q   <= '0;
            irq_data_q  <= '0;
            ints_prev_q <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            for (int i = 0; i < int'(NUM_INT); i++) begin
                data_lat_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            irq_q       <= irq_d;
            irq_vec_q   <= irq_vec_d;
            irq_data_q  <= irq_data_d;
            ints_prev_q <= ints;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            for (int i = 0; i < int'(NUM_INT); i++) begin
                if (rise_c[i]) begin
                    data_lat_q[i] <= ints_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign S_PREADY = en_c;
    assign S_PRDATA = rdata_c;
    assign irq      = irq_q;
    assign irq_vec  = irq_vec_q;
    assign irq_data = irq_data_q;

endmodule

// File: tb/tb_vmicro16_intc_apb.sv
// Directed bench for vmicro16_intc_apb: reset, priority, edge detect, masking,
// set-wins-over-clear, software trigger and mid-request reset.
module tb_vmicro16_intc_apb;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  S_PADDR;
    logic         S_PWRITE, S_PSELx, S_PENABLE;
    logic [15:0]  S_PWDATA;
    logic [15:0]  S_PRDATA;
    logic         S_PREADY;
    logic [7:0]   ints;
    logic [127:0] ints_data;
    logic         irq;
    logic [2:0]   irq_vec;
    logic [15:0]  irq_data;
    logic         irq_ack;

    int n_checks = 0;
    int n_fail   = 0;

    vmicro16_intc_apb dut (
        .clk(clk), .reset(reset),
        .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx),
        .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA),
        .S_PREADY(S_PREADY), .ints(ints), .ints_data(ints_data),
        .irq(irq), .irq_vec(irq_vec), .irq_data(irq_data), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [1:0] a, input logic [15:0] d);
        tick();
        S_PSELx = 1'b1; S_PWRITE = 1'b1; S_PENABLE = 1'b0;
        S_PADDR = 16'(a); S_PWDATA = d;
        tick();
        S_PENABLE = 1'b1;
        tick();
        S_PSELx = 1'b0; S_PENABLE = 1'b0; S_PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [1:0] a, output logic [15:0] d);
        tick();
        S_PSELx = 1'b1; S_PWRITE = 1'b0; S_PENABLE = 1'b0; S_PADDR = 16'(a);
        tick();
        S_PENABLE = 1'b1;
        #1 d = S_PRDATA;
        tick();
        S_PSELx = 1'b0; S_PENABLE = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        S_PADDR = '0; S_PWRITE = 1'b0; S_PSELx = 1'b0; S_PENABLE = 1'b0;
        S_PWDATA = '0; ints = '0; ints_data = '0; irq_ack = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({irq, irq_vec, irq_data} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got irq=%b vec=%0d data=%h, expected 0/0/0000", irq, irq_vec, irq_data);
        end
        n_checks++;
        if (S_PREADY !== 1'b0 || S_PRDATA !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_apb: got pready=%b prdata=%h, expected 0/0000", S_PREADY, S_PRDATA);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] rd;
        apb_write(2'd1, 16'h0001);
        ints_data[15:0] = 16'h1234;
        ints = 8'h01;
        tick();
        ints = 8'h00;
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency_early: got irq=%b, expected 0", irq);
        end
        tick();
        n_checks++;
        if (irq !== 1'b1 || irq_vec !== 3'd0 || irq_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL basic_irq: got irq=%b vec=%0d data=%h, expected 1/0/1234", irq, irq_vec, irq_data);
        end
        pulse_ack();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ack_drop: got irq=%b, expected 0", irq);
        end
        apb_read(2'd0, rd);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL basic_pend_after_ack: got %h, expected 0000", rd);
        end
        apb_read(2'd2, rd);
        n_checks++;
        if (rd !== 16'h8000) begin
            n_fail++;
            $display("FAIL basic_stat_serv: got %h, expected 8000", rd);
        end
        apb_write(2'd2, 16'h0000);
        apb_read(2'd2, rd);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL basic_stat_idle: got %h, expected 0000", rd);
        end
    endtask

    task automatic test_priority();
        logic [15:0] rd;
        apb_write(2'd1, 16'h00FF);
        ints_data[2*16 +: 16] = 16'h2222;
        ints_data[5*16 +: 16] = 16'h5555;
        ints = 8'h24;
        tick();
        ints = 8'h00;
        tick();
        n_checks++;
        if (irq !== 1'b1 || irq_vec !== 3'd2 || irq_data !== 16'h2222) begin
            n_fail++;
            $display("FAIL prio_first: got irq=%b vec=%0d data=%h, expected 1/2/2222", irq, irq_vec, irq_data);
        end
        pulse_ack();
        // Serving bit 2 must not issue the pending bit 5 before EOI
        repeat (3) tick();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_no_irq_in_serv: got irq=%b, expected 0", irq);
        end
        apb_write(2'd2, 16'hFFFF);
        tick();
        n_checks++;
        if (irq !== 1'b1 || irq_vec !== 3'd5 || irq_data !== 16'h5555) begin
            n_fail++;
            $display("FAIL prio_second: got irq=%b vec=%0d data=%h, expected 1/5/5555", irq, irq_vec, irq_data);
        end
        apb_read(2'd0, rd);
        n_checks++;
        if (rd !== 16'h0020) begin
            n_fail++;
            $display("FAIL prio_pend: got %h, expected 0020", rd);
        end
        apb_read(2'd2, rd);
        n_checks++;
        if (rd !== 16'h4005) begin
            n_fail++;
            $display("FAIL prio_stat_req: got %h, expected 4005", rd);
        end
        pulse_ack();
        apb_write(2'd2, 16'h0000);
    endtask

    task automatic test_level_hold();
        logic [15:0] rd;
        int extra;
        apb_write(2'd1, 16'h0002);
        ints_data[1*16 +: 16] = 16'h0B0B;
        ints = 8'h02;
        tick();
        tick();
        n_checks++;
        if (irq !== 1'b1 || irq_vec !== 3'd1 || irq_data !== 16'h0B0B) begin
            n_fail++;
            $display("FAIL level_irq: got irq=%b vec=%0d data=%h, expected 1/1/0b0b", irq, irq_vec, irq_data);
        end
        pulse_ack();
        apb_write(2'd2, 16'h0000);
        extra = 0;
        for (int c = 0; c < 42; c++) begin
            tick();
            if (irq) extra++;
        end
        ints = 8'h00;
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL level_single_event: got %0d irq cycles, expected 0", extra);
        end
        apb_read(2'd0, rd);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL level_pend: got %h, expected 0000", rd);
        end
    endtask

    task automatic test_mask();
        logic [15:0] rd;
        apb_write(2'd1, 16'h0000);
        ints = 8'h08;
        tick();
        ints = 8'h00;
        repeat (3) tick();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_blocks: got irq=%b, expected 0", irq);
        end
        apb_read(2'd0, rd);
        n_checks++;
        if (rd !== 16'h0008) begin
            n_fail++;
            $display("FAIL mask_pend_persist: got %h, expected 0008", rd);
        end
        apb_write(2'd1, 16'h0008);
        tick();
        n_checks++;
        if (irq !== 1'b1 || irq_vec !== 3'd3) begin
            n_fail++;
            $display("FAIL mask_unmask_irq: got irq=%b vec=%0d, expected 1/3", irq, irq_vec);
        end
        pulse_ack();
        apb_write(2'd2, 16'h0000);
        apb_write(2'd1, 16'h0000);
    endtask

    task automatic test_set_wins();
        logic [15:0] rd;
        tick();
        S_PSELx = 1'b1; S_PWRITE = 1'b1; S_PENABLE = 1'b0;
        S_PADDR = 16'h0000; S_PWDATA = 16'h0008;
        tick();
        S_PENABLE = 1'b1;
        ints = 8'h08;
        tick();
        S_PSELx = 1'b0; S_PENABLE = 1'b0; S_PWRITE = 1'b0;
        ints = 8'h00;
        apb_read(2'd0, rd);
        n_checks++;
        if (rd !== 16'h0008) begin
            n_fail++;
            $display("FAIL setwins_pend: got %h, expected 0008", rd);
        end
        apb_write(2'd0, 16'h0008);
        apb_read(2'd0, rd);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL w1c_pend: got %h, expected 0000", rd);
        end
    endtask

    task automatic test_swtrig_reset();
        logic [15:0] rd;
        apb_write(2'd1, 16'h0040);
        apb_write(2'd3, 16'h0040);
        tick();
        n_checks++;
        if (irq !== 1'b1 || irq_vec !== 3'd6 || irq_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL swtrig_irq: got irq=%b vec=%0d data=%h, expected 1/6/0000", irq, irq_vec, irq_data);
        end
        apb_read(2'd3, rd);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL swtrig_read: got %h, expected 0000", rd);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (irq !== 1'b0 || irq_vec !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset_irq: got irq=%b vec=%0d, expected 0/0", irq, irq_vec);
        end
        tick();
        reset = 1'b1;
        apb_read(2'd1, rd);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mask: got %h, expected 0000", rd);
        end
        apb_read(2'd0, rd);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_pend: got %h, expected 0000", rd);
        end
        apb_read(2'd2, rd);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_stat: got %h, expected 0000", rd);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_level_hold();
        test_mask();
        test_set_wins();
        test_swtrig_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
